// File: rtl/aes_pkg.sv
// Shared AES definitions for the round-key bank.
// Latency: none (constants, types and a pure combinational helper).
// Backpressure: not applicable.
// Contents: block/round-count constants, bank state type, byte_reverse().
package aes_pkg;

   localparam int AES_BLK_W = 128;
   localparam int NR_128    = 10;
   localparam int NR_192    = 12;
   localparam int NR_256    = 14;

   // Widest key the byte_reverse helper is sized for (AES-256 key width).
   localparam int MAX_KEY_W = 256;

   typedef enum logic [1:0] {
      KB_EMPTY,
      KB_FILLING,
      KB_READY
   } kbank_state_t;

   // Reverses the order of the lowest nbytes byte lanes of d.
   // Byte 0 (the most significant lane of a KEY_W-bit key) ends up at the LSB end.
   // Callers zero-extend their key to MAX_KEY_W and truncate the result back.
   function automatic logic [MAX_KEY_W-1:0] byte_reverse(input logic [MAX_KEY_W-1:0] d,
                                                         input int nbytes);
      logic [MAX_KEY_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_KEY_W/8; i++) begin
         if (i < nbytes) begin
            r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_round_key_bank_if.sv
// Handshake/bus bundle between the key-expansion/round datapath and the round-key bank.
// Latency: none (wiring only).
// Backpressure: write side is valid/ready; read side is request/valid with error flag.
// master: drives clear, write channel and read request; slave: the bank itself.
interface aes_round_key_bank_if #(
   parameter int KEY_W = 128,
   parameter int IDX_W = 4
);
   logic             clear;
   logic             wr_valid;
   logic             wr_ready;
   logic [KEY_W-1:0] wr_key;
   logic             rd_en;
   logic [IDX_W-1:0] rd_round;
   logic [KEY_W-1:0] rd_key;
   logic [IDX_W-1:0] rd_round_out;
   logic             rd_valid;
   logic             rd_err;
   logic             bank_ready;
   logic [IDX_W-1:0] wr_ptr;

   modport master (
      output clear, wr_valid, wr_key, rd_en, rd_round,
      input  wr_ready, rd_key, rd_round_out, rd_valid, rd_err, bank_ready, wr_ptr
   );

   modport slave (
      input  clear, wr_valid, wr_key, rd_en, rd_round,
      output wr_ready, rd_key, rd_round_out, rd_valid, rd_err, bank_ready, wr_ptr
   );
endinterface

// File: rtl/round_key_ram.sv
// NUM_KEYS x KEY_W key storage: synchronous write port, asynchronous read port.
// Latency: write lands on the clock edge; read data is combinational from the address.
// Backpressure: none; the caller only writes in-range slots.
// Ports: clk, we_i/wr_addr_i/wr_dat_i (write), rd_addr_i -> rd_dat_o (read).
module round_key_ram #(
   parameter int KEY_W    = 128,
   parameter int NUM_KEYS = 11,
   parameter int IDX_W    = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_addr_i,
   input  logic [KEY_W-1:0] wr_dat_i,
   input  logic [IDX_W-1:0] rd_addr_i,
   output logic [KEY_W-1:0] rd_dat_o
);
   localparam logic [IDX_W:0] NK = (IDX_W+1)'(NUM_KEYS);

   // Deliberately no reset: slots are only reachable after a full refill.
   logic [KEY_W-1:0] mem_q [NUM_KEYS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   // Out-of-range addresses return zero; the bank never forwards them anyway.
   assign rd_dat_o = ({1'b0, rd_addr_i} < NK) ? mem_q[rd_addr_i] : '0;
endmodule

// File: rtl/aes_round_key_bank.sv
// Round-key store: fills NUM_KEYS keys in order, then serves indexed reads with a round tag.
// Latency: read data, tag, valid and error are registered, one cycle after rd_en.
// Backpressure: wr_ready drops once all slots are filled; clear silently drops a same-cycle write.
// Ports: clk, rst (async active-low), bus (slave side of aes_round_key_bank_if).
module aes_round_key_bank
   import aes_pkg::*;
#(
   parameter int KEY_W    = 128,
   parameter int NUM_KEYS = 11,
   parameter int IDX_W    = 4,
   parameter int BYTE_REV = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   aes_round_key_bank_if.slave  bus
);
   localparam logic [IDX_W:0] NK = (IDX_W+1)'(NUM_KEYS);
   localparam int             NB = KEY_W / 8;

   kbank_state_t     state_q, state_d;
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [KEY_W-1:0] rd_key_q, rd_key_d;
   logic [IDX_W-1:0] rd_round_out_q, rd_round_out_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_err_q, rd_err_d;

   logic             not_full;
   logic             wr_fire;
   logic             rd_acc;
   logic [IDX_W:0]   ptr_inc;
   logic [KEY_W-1:0] ram_dat;
   logic [KEY_W-1:0] key_src;

   // wr_ready/bank_ready come from the state register only, so no input-to-output path.
   // clear gates write acceptance internally instead of through wr_ready.
   assign not_full = (state_q != KB_READY);
   assign wr_fire  = bus.wr_valid && not_full && !bus.clear;
   assign rd_acc   = bus.rd_en && (state_q == KB_READY) && ({1'b0, bus.rd_round} < NK);
   assign ptr_inc  = {1'b0, wr_ptr_q} + (IDX_W+1)'(1);

   round_key_ram #(
      .KEY_W    (KEY_W),
      .NUM_KEYS (NUM_KEYS),
      .IDX_W    (IDX_W)
   ) u_ram (
      .clk       (clk),
      .we_i      (wr_fire),
      .wr_addr_i (wr_ptr_q),
      .wr_dat_i  (bus.wr_key),
      .rd_addr_i (bus.rd_round),
      .rd_dat_o  (ram_dat)
   );

   always_comb begin
      if (BYTE_REV != 0) begin
         key_src = KEY_W'(byte_reverse(MAX_KEY_W'(ram_dat), NB));
      end else begin
         key_src = ram_dat;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      if (bus.clear) begin
         state_d  = KB_EMPTY;
         wr_ptr_d = '0;
      end else if (wr_fire) begin
         wr_ptr_d = ptr_inc[IDX_W-1:0];
         state_d  = (ptr_inc == NK) ? KB_READY : KB_FILLING;
      end

      // Reads are independent of clear: a READY bank still answers in the clear cycle.
      rd_valid_d     = rd_acc;
      rd_err_d       = bus.rd_en && !rd_acc;
      rd_key_d       = rd_acc ? key_src : rd_key_q;
      rd_round_out_d = rd_acc ? bus.rd_round : rd_round_out_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= KB_EMPTY;
         wr_ptr_q       <= '0;
         rd_key_q       <= '0;
         rd_round_out_q <= '0;
         rd_valid_q     <= 1'b0;
         rd_err_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_key_q       <= rd_key_d;
         rd_round_out_q <= rd_round_out_d;
         rd_valid_q     <= rd_valid_d;
         rd_err_q       <= rd_err_d;
      end
   end

   assign bus.wr_ready     = not_full;
   assign bus.bank_ready   = (state_q == KB_READY);
   assign bus.wr_ptr       = wr_ptr_q;
   assign bus.rd_key       = rd_key_q;
   assign bus.rd_round_out = rd_round_out_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_err       = rd_err_q;
endmodule

// File: tb/tb_aes_round_key_bank.sv
// Directed self-checking bench for aes_round_key_bank (FIPS-197 AES-128 key schedule vectors).
// Two instances share stimulus: BYTE_REV=0 (main checks) and BYTE_REV=1 (byte-order check).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_aes_round_key_bank;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   aes_round_key_bank_if #(.KEY_W(128), .IDX_W(4)) bus0 ();
   aes_round_key_bank_if #(.KEY_W(128), .IDX_W(4)) bus1 ();

   assign bus1.clear    = bus0.clear;
   assign bus1.wr_valid = bus0.wr_valid;
   assign bus1.wr_key   = bus0.wr_key;
   assign bus1.rd_en    = bus0.rd_en;
   assign bus1.rd_round = bus0.rd_round;

   aes_round_key_bank #(.KEY_W(128), .NUM_KEYS(11), .IDX_W(4), .BYTE_REV(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   aes_round_key_bank #(.KEY_W(128), .NUM_KEYS(11), .IDX_W(4), .BYTE_REV(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // FIPS-197 appendix A.1 round keys for key 2b7e151628aed2a6abf7158809cf4f3c.
   logic [127:0] kx [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   logic [127:0] nx [11];
   logic [127:0] mx [11];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus0.clear    = 1'b0;
      bus0.wr_valid = 1'b0;
      bus0.wr_key   = '0;
      bus0.rd_en    = 1'b0;
      bus0.rd_round = '0;
   endtask

   task automatic fill(input bit use_m);
      for (int i = 0; i < 11; i++) begin
         bus0.wr_valid = 1'b1;
         bus0.wr_key   = use_m ? mx[i] : nx[i];
         step();
      end
      bus0.wr_valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] r);
      bus0.rd_en    = 1'b1;
      bus0.rd_round = r;
      step();
      bus0.rd_en    = 1'b0;
   endtask

   initial begin
      int acc;
      for (int i = 0; i < 11; i++) begin
         nx[i] = kx[i] ^ {16{8'hA5}};
         mx[i] = kx[i] ^ {16{8'h3C}};
      end

      // Reset values.
      rst = 1'b0;
      idle();
      #12;
      chk("rst_wr_ptr",     bus0.wr_ptr, 0);
      chk("rst_wr_ready",   bus0.wr_ready, 1);
      chk("rst_bank_ready", bus0.bank_ready, 0);
      chk("rst_rd_valid",   bus0.rd_valid, 0);
      chk("rst_rd_err",     bus0.rd_err, 0);
      chk("rst_rd_key",     bus0.rd_key, 0);
      chk("rst_rd_round",   bus0.rd_round_out, 0);
      @(negedge clk);
      rst = 1'b1;

      // wr_valid held for 14 cycles: only 11 writes accepted.
      acc = 0;
      for (int c = 1; c <= 14; c++) begin
         bus0.wr_valid = 1'b1;
         bus0.wr_key   = (c <= 11) ? kx[c-1] : 128'hdead_beef;
         if (bus0.wr_ready) acc++;
         if (c == 12) chk("wr_ready_c12", bus0.wr_ready, 0);
         if (c == 14) chk("wr_ready_c14", bus0.wr_ready, 0);
         step();
      end
      bus0.wr_valid = 1'b0;
      chk("accepted_writes", acc, 11);
      chk("full_wr_ptr",     bus0.wr_ptr, 11);
      chk("full_bank_ready", bus0.bank_ready, 1);

      // Back-to-back reads of every round.
      for (int r = 0; r < 11; r++) begin
         bus0.rd_en    = 1'b1;
         bus0.rd_round = 4'(r);
         step();
         chk($sformatf("rd_key_r%0d", r), bus0.rd_key, kx[r]);
         chk($sformatf("rd_tag_r%0d", r), bus0.rd_round_out, r);
         chk($sformatf("rd_vld_r%0d", r), bus0.rd_valid, 1);
         if (r == 0) chk("rev_rd_key_r0", bus1.rd_key, 128'h3c4fcf098815f7aba6d2ae2816157e2b);
      end
      chk("rd_key_r10_fips", bus0.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Out-of-range index while READY.
      rd(4'd11);
      chk("oor_err",   bus0.rd_err, 1);
      chk("oor_valid", bus0.rd_valid, 0);
      chk("oor_hold",  bus0.rd_key, kx[10]);

      // Idle cycle: flags drop, data holds.
      step();
      chk("idle_valid", bus0.rd_valid, 0);
      chk("idle_err",   bus0.rd_err, 0);
      chk("idle_key",   bus0.rd_key, kx[10]);
      chk("idle_tag",   bus0.rd_round_out, 10);

      // clear + write + read in one READY cycle.
      bus0.clear    = 1'b1;
      bus0.wr_valid = 1'b1;
      bus0.wr_key   = 128'hbad0_bad0;
      bus0.rd_en    = 1'b1;
      bus0.rd_round = 4'd4;
      step();
      idle();
      chk("clr_wr_ptr",     bus0.wr_ptr, 0);
      chk("clr_wr_ready",   bus0.wr_ready, 1);
      chk("clr_bank_ready", bus0.bank_ready, 0);
      chk("clr_rd_valid",   bus0.rd_valid, 1);
      chk("clr_rd_key",     bus0.rd_key, kx[4]);

      // Refill after clear: dropped key never stored, first write in slot 0.
      fill(1'b0);
      chk("refill_ready", bus0.bank_ready, 1);
      rd(4'd0);
      chk("refill_slot0", bus0.rd_key, nx[0]);
      rd(4'd10);
      chk("refill_slot10", bus0.rd_key, nx[10]);

      // Partial fill then a read while FILLING.
      bus0.clear = 1'b1;
      step();
      bus0.clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus0.wr_valid = 1'b1;
         bus0.wr_key   = mx[i];
         step();
      end
      bus0.wr_valid = 1'b0;
      chk("part_wr_ptr", bus0.wr_ptr, 5);
      rd(4'd3);
      chk("filling_err",   bus0.rd_err, 1);
      chk("filling_valid", bus0.rd_valid, 0);
      chk("filling_hold",  bus0.rd_key, nx[10]);

      // Reset pulled during the 6th write.
      bus0.wr_valid = 1'b1;
      bus0.wr_key   = mx[5];
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_wr_ptr",     bus0.wr_ptr, 0);
      chk("mid_rst_bank_ready", bus0.bank_ready, 0);
      chk("mid_rst_wr_ready",   bus0.wr_ready, 1);
      chk("mid_rst_rd_key",     bus0.rd_key, 0);
      bus0.wr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      fill(1'b1);
      chk("post_rst_ready", bus0.bank_ready, 1);
      for (int r = 0; r < 11; r++) begin
         rd(4'(r));
         chk($sformatf("post_rst_key_r%0d", r), bus0.rd_key, mx[r]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Hard time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
